// File: rtl/dmem_uart_tx_pkg.sv
// Shared constants and types for the memory-mapped UART transmitter:
// register offsets, STATUS/CTRL bit positions and the serializer state enum.
package dmem_uart_tx_pkg;

    localparam logic [1:0] REG_TXDATA   = 2'd0;
    localparam logic [1:0] REG_STATUS   = 2'd1;
    localparam logic [1:0] REG_BAUD_DIV = 2'd2;
    localparam logic [1:0] REG_CTRL     = 2'd3;

    localparam int STAT_BUSY      = 0;
    localparam int STAT_EMPTY     = 1;
    localparam int STAT_FULL      = 2;
    localparam int STAT_OVERFLOW  = 3;
    localparam int STAT_COUNT_LSB = 8;

    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_FLUSH  = 1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_tx_state_t;

endpackage

// File: rtl/dmem_uart_tx_fifo.sv
// Byte FIFO feeding the UART serializer. A push while full only lands if a
// pop frees a slot on the same edge; flush drops every queued entry.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + ONE_CNT;
                2'b01:   count <= count - ONE_CNT;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dmem_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the data-memory bus. Stores to
// TXDATA queue bytes; the serializer drains them with a latched divisor.
module dmem_uart_tx
    import dmem_uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic        dmem_wen,
    input  logic [3:0]  dmem_wr_mask,
    output logic [31:0] dmem_rdata,
    output logic        tx,
    output logic        irq_empty
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic           hit, wr;
    logic [1:0]     sel;
    logic           fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
    logic [7:0]     fifo_dout;
    logic [CW-1:0]  fifo_count;
    logic           overflow, enable, busy;
    logic [15:0]    baud_div, eff_div;

    uart_tx_state_t state, next_state;
    logic [15:0]    div_cnt, next_cnt, div_lat, next_div;
    logic [2:0]     bit_idx, next_bit;
    logic [7:0]     shreg, next_shreg;
    logic           next_tx, bit_end, start_frame;
    logic           unused_bits;

    assign hit        = (dmem_addr[31:4] == BASE_ADDR[31:4]);
    assign sel        = dmem_addr[3:2];
    assign wr         = hit && dmem_wen;
    assign fifo_push  = wr && (sel == REG_TXDATA) && dmem_wr_mask[0];
    assign fifo_flush = wr && (sel == REG_CTRL) && dmem_wr_mask[0] && dmem_wdata[CTRL_FLUSH];
    assign eff_div    = (baud_div == 16'd0) ? 16'd1 : baud_div;
    assign busy       = (state != IDLE);
    assign bit_end    = (div_cnt == div_lat - 16'd1);
    assign unused_bits = ^{dmem_addr[1:0], dmem_wdata[31:16], dmem_wr_mask[3:2]};

    sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .din   (dmem_wdata[7:0]),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // A push that coincides with a pop on a full FIFO still lands, so no overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
            baud_div <= DEFAULT_DIV;
            enable   <= 1'b1;
        end else begin
            if (fifo_push && fifo_full && !fifo_pop)
                overflow <= 1'b1;
            else if (wr && sel == REG_STATUS && dmem_wr_mask[0] && dmem_wdata[STAT_OVERFLOW])
                overflow <= 1'b0;
            if (wr && sel == REG_BAUD_DIV) begin
                if (dmem_wr_mask[0]) baud_div[7:0]  <= dmem_wdata[7:0];
                if (dmem_wr_mask[1]) baud_div[15:8] <= dmem_wdata[15:8];
            end
            if (wr && sel == REG_CTRL && dmem_wr_mask[0])
                enable <= dmem_wdata[CTRL_ENABLE];
        end
    end

    always_comb begin
        dmem_rdata = '0;
        if (hit) begin
            case (sel)
                REG_STATUS: begin
                    dmem_rdata[STAT_BUSY]     = busy;
                    dmem_rdata[STAT_EMPTY]    = fifo_empty;
                    dmem_rdata[STAT_FULL]     = fifo_full;
                    dmem_rdata[STAT_OVERFLOW] = overflow;
                    dmem_rdata[STAT_COUNT_LSB +: 8] = 8'(fifo_count);
                end
                REG_BAUD_DIV: dmem_rdata[15:0] = baud_div;
                REG_CTRL:     dmem_rdata[CTRL_ENABLE] = enable;
                default:      dmem_rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            div_cnt   <= '0;
            div_lat   <= 16'd1;
            bit_idx   <= '0;
            shreg     <= '0;
            tx        <= 1'b1;
            irq_empty <= 1'b1;
        end else begin
            state     <= next_state;
            div_cnt   <= next_cnt;
            div_lat   <= next_div;
            bit_idx   <= next_bit;
            shreg     <= next_shreg;
            tx        <= next_tx;
            irq_empty <= fifo_empty && (state == IDLE);
        end
    end

    // Next tx is decided here so the line changes on the same edge as the state.
    always_comb begin
        next_state  = state;
        next_cnt    = div_cnt;
        next_div    = div_lat;
        next_bit    = bit_idx;
        next_shreg  = shreg;
        next_tx     = tx;
        start_frame = 1'b0;
        fifo_pop    = 1'b0;
        case (state)
            IDLE: begin
                next_tx = 1'b1;
                if (enable && !fifo_empty) start_frame = 1'b1;
            end
            START: begin
                if (bit_end) begin
                    next_state = DATA;
                    next_cnt   = '0;
                    next_bit   = '0;
                    next_tx    = shreg[0];
                end else begin
                    next_cnt = div_cnt + 16'd1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    next_cnt = '0;
                    if (bit_idx == 3'd7) begin
                        next_state = STOP;
                        next_tx    = 1'b1;
                    end else begin
                        next_bit   = bit_idx + 3'd1;
                        next_shreg = {1'b0, shreg[7:1]};
                        next_tx    = shreg[1];
                    end
                end else begin
                    next_cnt = div_cnt + 16'd1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    next_state = IDLE;
                    next_tx    = 1'b1;
                    if (enable && !fifo_empty) start_frame = 1'b1;
                end else begin
                    next_cnt = div_cnt + 16'd1;
                end
            end
            default: next_state = IDLE;
        endcase
        if (start_frame) begin
            fifo_pop   = 1'b1;
            next_shreg = fifo_dout;
            next_div   = eff_div;
            next_cnt   = '0;
            next_state = START;
            next_tx    = 1'b0;
        end
    end

endmodule

// File: tb/tb_dmem_uart_tx.sv
// Scoreboard bench for dmem_uart_tx: queued bytes are checked against a
// serial-line monitor that verifies every cycle of each 8N1 frame.
module tb_dmem_uart_tx;

    localparam logic [31:0] BASE = 32'h0001_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] dmem_addr = '0;
    logic [31:0] dmem_wdata = '0;
    logic        dmem_wen = 1'b0;
    logic [3:0]  dmem_wr_mask = '0;
    logic [31:0] dmem_rdata;
    logic        tx;
    logic        irq_empty;

    typedef struct {
        logic [7:0] data;
        int         div;
    } exp_t;

    exp_t exp_q[$];
    int   frame_starts[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   cur_div = 4;
    int   store_cyc;
    bit   mon_en = 1'b1;
    bit   mon_busy = 1'b0;
    logic [31:0] rd;

    dmem_uart_tx #(
        .BASE_ADDR   (BASE),
        .FIFO_DEPTH  (8),
        .DEFAULT_DIV (16'd4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_wen     (dmem_wen),
        .dmem_wr_mask (dmem_wr_mask),
        .dmem_rdata   (dmem_rdata),
        .tx           (tx),
        .irq_empty    (irq_empty)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] mask);
        dmem_addr    = addr;
        dmem_wdata   = wdata;
        dmem_wr_mask = mask;
        dmem_wen     = 1'b1;
        @(posedge clk);
        #1;
        dmem_wen = 1'b0;
    endtask

    task automatic readReg(input logic [31:0] addr, output logic [31:0] data);
        dmem_wen  = 1'b0;
        dmem_addr = addr;
        #1;
        data = dmem_rdata;
    endtask

    task automatic sendByte(input logic [7:0] b, input bit expect_it);
        exp_t e;
        e.data = b;
        e.div  = cur_div;
        if (expect_it) exp_q.push_back(e);
        applyStimulus(BASE + 32'h0, {24'h0, b}, 4'b0001);
    endtask

    task automatic setBaud(input logic [15:0] v);
        applyStimulus(BASE + 32'h8, {16'h0, v}, 4'b0011);
        cur_div = (v == 16'd0) ? 1 : int'(v);
    endtask

    task automatic waitDrain(input int maxc);
        for (int i = 0; i < maxc && (exp_q.size() != 0 || mon_busy); i++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("drain", 32'(exp_q.size() != 0 || mon_busy), 32'd0);
    endtask

    // Serial monitor: every cycle of every bit is compared against the expected level.
    initial begin
        exp_t e;
        logic [9:0] rx;
        logic [9:0] want;
        int bad;
        forever begin
            @(negedge clk);
            if (mon_en && rst_n && tx === 1'b0) begin
                mon_busy = 1'b1;
                frame_starts.push_back(cyc);
                checkOutput("frame_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) e = exp_q.pop_front();
                else begin
                    e.data = 8'h00;
                    e.div  = cur_div;
                end
                want = {1'b1, e.data, 1'b0};
                rx  = '0;
                bad = 0;
                for (int b = 0; b < 10; b++) begin
                    for (int c = 0; c < e.div; c++) begin
                        if (!(b == 0 && c == 0)) @(negedge clk);
                        if (tx !== want[b]) bad++;
                        if (c == e.div / 2) rx[b] = tx;
                    end
                end
                checkOutput("frame_data", 32'(rx), 32'(want));
                checkOutput("frame_timing", 32'(bad), 32'd0);
                mon_busy = 1'b0;
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset state and register reads
        checkOutput("rst_tx", 32'(tx), 32'd1);
        checkOutput("rst_irq", 32'(irq_empty), 32'd1);
        readReg(BASE + 32'h8, rd);  checkOutput("rst_baud", rd, 32'h0000_0004);
        readReg(BASE + 32'h4, rd);  checkOutput("rst_status", rd, 32'h0000_0002);
        readReg(BASE + 32'hC, rd);  checkOutput("rst_ctrl", rd, 32'h0000_0001);
        readReg(BASE + 32'h0, rd);  checkOutput("txdata_read", rd, 32'h0);
        readReg(32'h0000_0008, rd); checkOutput("miss_read", rd, 32'h0);

        // Non-hit store ignored; masked-out lanes keep their bytes
        applyStimulus(32'h0000_0008, 32'h0000_0077, 4'b1111);
        readReg(BASE + 32'h8, rd);  checkOutput("miss_write", rd, 32'h0000_0004);
        applyStimulus(BASE + 32'h8, 32'hFFFF_AB09, 4'b0001);
        readReg(BASE + 32'h8, rd);  checkOutput("baud_lane0", rd, 32'h0000_0009);
        applyStimulus(BASE + 32'h8, 32'hFFFF_0300, 4'b0010);
        readReg(BASE + 32'h8, rd);  checkOutput("baud_lane1", rd, 32'h0000_0309);
        setBaud(16'd4);

        // Single frame 0x55: latency, 40-cycle frame, irq_empty lag
        frame_starts.delete();
        sendByte(8'h55, 1'b1);
        store_cyc = cyc;
        for (int i = 1; i <= 42; i++) begin
            @(posedge clk);
            #1;
            if (i == 1)  checkOutput("irq_busy", 32'(irq_empty), 32'd0);
            if (i == 41) checkOutput("irq_lag", 32'(irq_empty), 32'd0);
            if (i == 42) checkOutput("irq_rise", 32'(irq_empty), 32'd1);
        end
        checkOutput("start_latency", 32'(frame_starts.size() > 0 ? frame_starts[0] - store_cyc : -1), 32'd1);
        waitDrain(100);

        // Fill to full, then overflow, then W1C clear
        for (int i = 0; i < 9; i++) sendByte(8'(i), 1'b1);
        readReg(BASE + 32'h4, rd);  checkOutput("fifo_full", rd, 32'h0000_0805);
        for (int i = 0; i < 10; i++) sendByte(8'(8'h80 + i), 1'b0);
        readReg(BASE + 32'h4, rd);  checkOutput("overflow_set", rd, 32'h0000_080D);
        applyStimulus(BASE + 32'h4, 32'h0000_0008, 4'b0001);
        readReg(BASE + 32'h4, rd);  checkOutput("overflow_clr", rd, 32'h0000_0805);
        waitDrain(1000);

        // Back-to-back frames with no idle gap
        frame_starts.delete();
        sendByte(8'hA5, 1'b1);
        sendByte(8'h3C, 1'b1);
        waitDrain(200);
        checkOutput("b2b_gap", 32'(frame_starts.size() == 2 ? frame_starts[1] - frame_starts[0] : -1), 32'd40);

        // Divisor change mid-frame applies to the next frame only; 0 acts as 1
        frame_starts.delete();
        sendByte(8'hFF, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        setBaud(16'd2);
        sendByte(8'h81, 1'b1);
        waitDrain(200);
        checkOutput("baud_gap", 32'(frame_starts.size() == 2 ? frame_starts[1] - frame_starts[0] : -1), 32'd40);
        setBaud(16'd0);
        sendByte(8'h5A, 1'b1);
        waitDrain(100);
        setBaud(16'd4);

        // Disabled transmitter holds queued data
        applyStimulus(BASE + 32'hC, 32'h0, 4'b0001);
        sendByte(8'h42, 1'b1);
        repeat (20) @(posedge clk);
        #1;
        readReg(BASE + 32'h4, rd);  checkOutput("disabled_hold", rd, 32'h0000_0100);
        readReg(BASE + 32'hC, rd);  checkOutput("ctrl_off", rd, 32'h0);
        applyStimulus(BASE + 32'hC, 32'h1, 4'b0001);
        waitDrain(100);

        // Flush with 5 queued bytes mid-frame
        for (int i = 0; i < 6; i++) sendByte(8'(8'h10 + i), 1'b1);
        repeat (4) @(posedge clk);
        #1;
        applyStimulus(BASE + 32'hC, 32'h3, 4'b0001);
        exp_q.delete();
        readReg(BASE + 32'h4, rd);  checkOutput("flush_busy", rd, 32'h0000_0003);
        readReg(BASE + 32'hC, rd);  checkOutput("flush_rd0", rd, 32'h0000_0001);
        waitDrain(100);
        readReg(BASE + 32'h4, rd);  checkOutput("flush_done", rd, 32'h0000_0002);
        repeat (20) @(posedge clk);
        #1;
        checkOutput("flush_tx_idle", 32'(tx), 32'd1);
        checkOutput("flush_irq", 32'(irq_empty), 32'd1);

        // Asynchronous reset in the middle of a data bit
        mon_en = 1'b0;
        sendByte(8'h00, 1'b0);
        repeat (8) @(posedge clk);
        #3;
        checkOutput("tx_mid_data", 32'(tx), 32'd0);
        rst_n = 1'b0;
        #1;
        checkOutput("tx_async_rst", 32'(tx), 32'd1);
        checkOutput("irq_async_rst", 32'(irq_empty), 32'd1);
        readReg(BASE + 32'h4, rd);  checkOutput("status_in_rst", rd, 32'h0000_0002);
        @(negedge clk);
        rst_n = 1'b1;
        readReg(BASE + 32'h8, rd);  checkOutput("baud_after_rst", rd, 32'h0000_0004);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
